// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory responder for the single-cycle RISC-V core. It accepts one
// load/store request at a time and performs it against an internal
// byte-addressable array after LATENCY access cycles. It then returns one
// response.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. Once valid is raised, the payload
// stays stable until that edge. The request channel is req_valid/req_ready.
// The response channel is rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   read_mem, write_mem   load / store strobes from decode
//   funct3                000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr, wdata           byte address, store data (low byte/half/word used)
//   rsp_valid/rsp_ready   response handshake
//   rdata                 load result, sign/zero extended; 0 for stores/errors
//   rsp_error             request rejected, no memory side effect
//   dbg_state             current FSM state (IDLE=0, ACCESS=1, RESP=2)
module data_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             read_mem,
  input  logic             write_mem,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             rsp_error,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [31:0]      mem [DEPTH];

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic             store_q;
  logic             err_q;
  logic [2:0]       f3_q;
  logic [AW-1:0]    idx_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rsp_error_q;

  logic             req_err;
  logic             commit;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;

  // Upper address bits are ignored (addresses wrap) and the wdata bits
  // above 31 are never stored. This keeps them visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{addr, wdata};

  // Request classification is evaluated at accept time. The verdict is
  // carried through ACCESS so that an error request keeps normal timing.
  always_comb begin
    req_err = 1'b0;
    if (read_mem == write_mem) begin
      req_err = 1'b1;
    end else begin
      case (funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = addr[0];
        3'b010:  req_err = |addr[1:0];
        3'b100:  req_err = write_mem;
        3'b101:  req_err = write_mem | addr[0];
        default: req_err = 1'b1;
      endcase
    end
  end

  assign commit = (state_q == ACCESS) && (cnt_q == '0);

  // Store lane steering: the data is replicated across lanes, and the byte
  // enables pick the addressed lane(s).
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << off_q;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Memory is not reset. A commit edge that coincides with rst is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && commit && store_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign word     = mem[idx_q];
  assign byte_sel = word[8*off_q +: 8];
  assign half_sel = off_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_val = WIDTH'($signed(byte_sel));
      3'b001:  load_val = WIDTH'($signed(half_sel));
      3'b100:  load_val = WIDTH'(byte_sel);
      3'b101:  load_val = WIDTH'(half_sel);
      default: load_val = WIDTH'(word);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= 3'b000;
      idx_q       <= '0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q <= write_mem;
            err_q   <= req_err;
            f3_q    <= funct3;
            idx_q   <= addr[AW+1:2];
            off_q   <= addr[1:0];
            wdata_q <= wdata[31:0];
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            rsp_error_q <= err_q;
            rdata_q     <= (err_q || store_q) ? '0 : load_val;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rdata     = rdata_q;
  assign rsp_error = rsp_error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. It runs directed scenarios followed by
// randomized load/store traffic. All traffic is checked against a
// byte-array reference model.
module tb_data_mem_responder;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int BYTES   = 4 * DEPTH;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             read_mem;
  logic             write_mem;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rdata;
  logic             rsp_error;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  data_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .read_mem(read_mem), .write_mem(write_mem), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata(rdata), .rsp_error(rsp_error), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_mem [BYTES];
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a request either fails the decode/alignment rules, or
  // moves 1/2/4 bytes between the bus and a flat byte array.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int size;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    off = int'(a % BYTES);
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    e = (rd == wr) || (size == 0) || (f3[2] && (size == 4 || wr)) || (off % size != 0);
    d = 32'd0;
    if (e) return;
    if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[off + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
      if (!f3[2] && size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        if (v[8*size-1]) v = v | ~mask;
      end
      d = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    req_valid = 1'b0;
    read_mem  = 1'b0;
    write_mem = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
  endtask

  // One complete transaction. The response is held back for `hold` cycles,
  // and a stray request is offered during the hold; it must be ignored.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] got);
    logic [31:0] ed;
    logic        ee;
    int          n;
    model(rd, wr, f3, a, wd, ed, ee);
    exp_q.push_back(ed);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; read_mem = rd; write_mem = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 idle_bus();
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid || n >= 20) break;
    end
    got = rdata;
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    chk("latency", 32'(n), 32'(LATENCY));
    chk("rdata", rdata, exp_q.pop_front());
    chk("rsp_error", 32'(rsp_error), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; write_mem = 1'b1; funct3 = 3'b010; addr = a; wdata = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rdata, ed);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    idle_bus();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Accept a word store, then reset `at` edges after the accept edge. If
  // at = LATENCY-1, the reset lands on the would-be commit edge.
  task automatic rst_mid(input logic [31:0] a, input logic [31:0] wd, input int at);
    @(negedge clk);
    req_valid = 1'b1; write_mem = 1'b1; funct3 = 3'b010; addr = a; wdata = wd;
    @(posedge clk);
    #1 idle_bus();
    repeat (at) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;

    idle_bus();
    rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rsp_error", 32'(rsp_error), 32'd0);
    rst = 1'b0;

    // Give bytes 0x00..0x3F known contents.
    for (int w = 0; w < 16; w++) run(1'b0, 1'b1, 3'b010, 32'(4 * w), $urandom, 0, got);

    // Word store / load and extension.
    run(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got);
    chk("sw_rdata_zero", got, 32'd0);
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, got);
    chk("lw_10", got, 32'hDEADBEEF);
    run(1'b1, 1'b0, 3'b000, 32'h13, 32'd0, 0, got);
    chk("lb_13", got, 32'hFFFFFFDE);
    run(1'b1, 1'b0, 3'b100, 32'h13, 32'd0, 0, got);
    chk("lbu_13", got, 32'h000000DE);
    run(1'b1, 1'b0, 3'b001, 32'h10, 32'd0, 0, got);
    chk("lh_10", got, 32'hFFFFBEEF);
    run(1'b1, 1'b0, 3'b101, 32'h12, 32'd0, 0, got);
    chk("lhu_12", got, 32'h0000DEAD);
    run(1'b0, 1'b1, 3'b000, 32'h11, 32'h11, 0, got);
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, got);
    chk("lw_after_sb", got, 32'hDEAD11EF);

    // Rejected requests: no side effect.
    run(1'b0, 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 0, got);
    chk("err_sw_mis", got, 32'd0);
    run(1'b1, 1'b0, 3'b001, 32'h11, 32'd0, 0, got);
    chk("err_lh_mis", got, 32'd0);
    run(1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 0, got);
    chk("err_both", got, 32'd0);
    run(1'b0, 1'b0, 3'b010, 32'h10, 32'hFFFFFFFF, 0, got);
    chk("err_none", got, 32'd0);
    run(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 0, got);
    chk("err_f3_011", got, 32'd0);
    run(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, got);
    chk("err_store_bu", got, 32'd0);
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, got);
    chk("lw_after_errs", got, 32'hDEAD11EF);

    // Backpressure with a stray request offered during the hold.
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 5, got);
    chk("lw_bp", got, 32'hDEAD11EF);
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, got);
    chk("lw_after_bp", got, 32'hDEAD11EF);

    // Address wrap.
    run(1'b0, 1'b1, 3'b010, 32'(BYTES + 32'h10), 32'h12345678, 0, got);
    run(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, got);
    chk("lw_wrap", got, 32'h12345678);

    // Reset mid-operation, both before and on the commit edge.
    prior = {ref_mem[32'h23], ref_mem[32'h22], ref_mem[32'h21], ref_mem[32'h20]};
    rst_mid(32'h20, 32'hCAFEF00D, 0);
    run(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 0, got);
    chk("lw_after_rst_early", got, prior);
    rst_mid(32'h20, 32'hCAFEF00D, LATENCY - 1);
    run(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 0, got);
    chk("lw_after_rst_commit", got, prior);

    // Randomized traffic over the initialised window, with aliased upper bits.
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel < 5) || (sel == 9);
      wr  = ((sel >= 5) && (sel < 9)) || (sel == 9);
      if (sel == 8) begin rd = 1'b0; wr = 1'b0; end
      f3  = 3'($urandom_range(0, 7));
      a   = ($urandom & ~32'(BYTES - 1)) | 32'($urandom_range(0, 63));
      run(rd, wr, f3, a, $urandom, $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
